adc_scan_seq: RTL and testbench



---
 rtl/adc_scan_pkg.sv | 19 +
 rtl/adc_scan_seq_cycle_timer.sv | 28 ++
 rtl/adc_scan_seq.sv | 159 +++++++++++++++
 tb/tb_adc_scan_seq.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/adc_scan_pkg.sv
// Shared types and constants for the 4-channel ADC scan sequencer.
// Holds the FSM state encoding, channel counts and the timeout fill value.
package adc_scan_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_WAIT  = 3'd2,
    S_NEXT  = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  localparam int NUM_CH   = 4;
  localparam int CH_SEL_W = 2;

  // Stored in place of a sample when a conversion times out
  localparam logic [63:0] TIMEOUT_FILL = '1;

endpackage

// File: rtl/adc_scan_seq_cycle_timer.sv
// Loadable down-counter with a zero flag.
// Used for the inter-frame gap and, optionally, the WAIT watchdog.
module cycle_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] value,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (dec && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/adc_scan_seq.sv
// Channel-scan sequencer driving the SPI ADC command mux select.
// Optional WAIT watchdog and err_o port: define ADC_SCAN_TIMEOUT_EN.
module adc_scan_seq
  import adc_scan_pkg::*;
#(
  parameter int Width         = 12,
  parameter int GapCycles     = 1000,
  parameter int TimeoutCycles = 4096
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                en_i,
  output logic [CH_SEL_W-1:0] sel_o,
  output logic                spi_start_o,
  input  logic                spi_done_i,
  input  logic [Width-1:0]    spi_data_i,
  output logic [Width-1:0]    ch0_o,
  output logic [Width-1:0]    ch1_o,
  output logic [Width-1:0]    ch2_o,
  output logic [Width-1:0]    ch3_o,
  output logic                frame_valid_o,
`ifdef ADC_SCAN_TIMEOUT_EN
  output logic                err_o,
`endif
  output logic                busy_o
);

  localparam int GapLoad = (GapCycles > 0) ? GapCycles - 1 : 0;
  localparam int GapW    = $clog2(GapLoad + 2);
  localparam logic [GapW-1:0] GAP_INIT = GapW'(GapLoad);
  localparam logic [CH_SEL_W-1:0] LAST_CH = CH_SEL_W'(NUM_CH - 1);

  state_t state, state_n;
  logic [CH_SEL_W-1:0] sel_q;
  logic [Width-1:0]    res_q [NUM_CH];
  logic [Width-1:0]    wdata;
  logic gap_load, gap_dec, gap_zero;
  logic wr, timeout;

  cycle_timer #(.W(GapW)) u_gap (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .load  (gap_load),
    .value (GAP_INIT),
    .dec   (gap_dec),
    .zero  (gap_zero)
  );

`ifdef ADC_SCAN_TIMEOUT_EN
  localparam int TW = $clog2(TimeoutCycles + 1);
  localparam logic [TW-1:0] TO_INIT = TW'(TimeoutCycles - 1);

  logic wd_zero, err_q;

  // Reloaded in START so the count begins fresh on every WAIT entry
  cycle_timer #(.W(TW)) u_wd (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .load  (state == S_START),
    .value (TO_INIT),
    .dec   (state == S_WAIT),
    .zero  (wd_zero)
  );

  assign timeout = (state == S_WAIT) && !spi_done_i && wd_zero;
  assign wdata   = spi_done_i ? spi_data_i : TIMEOUT_FILL[Width-1:0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else if (timeout) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  assign timeout = 1'b0;
  assign wdata   = spi_data_i;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n  = state;
    gap_load = 1'b0;
    gap_dec  = 1'b0;
    wr       = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (en_i) state_n = S_START;
      end
      S_START: begin
        state_n = S_WAIT;
      end
      S_WAIT: begin
        if (spi_done_i || timeout) begin
          wr      = 1'b1;
          state_n = S_NEXT;
        end
      end
      S_NEXT: begin
        if (sel_q != LAST_CH) begin
          state_n = S_START;
        end else if (!en_i) begin
          state_n = S_IDLE;
        end else if (GapCycles == 0) begin
          state_n = S_START;
        end else begin
          gap_load = 1'b1;
          state_n  = S_GAP;
        end
      end
      S_GAP: begin
        if (!en_i) begin
          state_n = S_IDLE;
        end else if (gap_zero) begin
          state_n = S_START;
        end else begin
          gap_dec = 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Wraps 3 -> 0 at frame end, so IDLE and GAP always see channel 0
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sel_q <= '0;
    end else if (state == S_NEXT) begin
      sel_q <= sel_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_CH; i++) res_q[i] <= '0;
    end else if (wr) begin
      res_q[sel_q] <= wdata;
    end
  end

  assign sel_o         = sel_q;
  assign spi_start_o   = (state == S_START);
  assign frame_valid_o = (state == S_NEXT) && (sel_q == LAST_CH);
  assign busy_o        = (state != S_IDLE);
  assign ch0_o         = res_q[0];
  assign ch1_o         = res_q[1];
  assign ch2_o         = res_q[2];
  assign ch3_o         = res_q[3];

endmodule

// File: tb/tb_adc_scan_seq.sv
// Self-checking bench for adc_scan_seq: random SPI latencies/data
// against a channel-level model of the scan, gap and reset behaviour.
module tb_adc_scan_seq;

  localparam int W   = 12;
  localparam int GAP = 5;
  localparam int TO  = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic         spi_done = 1'b0;
  logic [W-1:0] spi_data = '0;
  logic [1:0]   sel;
  logic         spi_start, fv, busy;
  logic [W-1:0] c0, c1, c2, c3;
`ifdef ADC_SCAN_TIMEOUT_EN
  logic         err;
`endif

  adc_scan_seq #(
    .Width(W), .GapCycles(GAP), .TimeoutCycles(TO)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .en_i          (en),
    .sel_o         (sel),
    .spi_start_o   (spi_start),
    .spi_done_i    (spi_done),
    .spi_data_i    (spi_data),
    .ch0_o         (c0),
    .ch1_o         (c1),
    .ch2_o         (c2),
    .ch3_o         (c3),
    .frame_valid_o (fv),
`ifdef ADC_SCAN_TIMEOUT_EN
    .err_o         (err),
`endif
    .busy_o        (busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  logic [W-1:0] exp_ch [4];
  logic exp_err = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] chv(input int i);
    case (i)
      0: return c0;
      1: return c1;
      2: return c2;
      default: return c3;
    endcase
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Entered on the START cycle of channel ch; leaves on the next START
  // (ch<3) or on the NEXT cycle carrying frame_valid (ch==3).
  task automatic do_channel(input int ch, input int lat,
                            input logic [W-1:0] d,
                            input bit silent, input bit drop);
    bit bad;
    bad = 1'b0;
    chk("start", spi_start, 1);
    chk("sel", sel, ch);
    if ($urandom_range(0, 1) == 1) begin
      spi_done = 1'b1;
      spi_data = W'($urandom);
    end
    tick;
    spi_done = 1'b0;
    if (drop) en = 1'b0;
    for (int k = 1; k < lat; k++) begin
      if (sel !== ch[1:0] || spi_start !== 1'b0 ||
          busy !== 1'b1 || fv !== 1'b0) bad = 1'b1;
      tick;
    end
    if (sel !== ch[1:0]) bad = 1'b1;
    if (!silent) begin
      spi_done = 1'b1;
      spi_data = d;
    end
    tick;
    spi_done = 1'b0;
    exp_ch[ch] = silent ? '1 : d;
    if (silent) exp_err = 1'b1;
    chk("sel_hold", bad, 0);
    chk("start_next", spi_start, 0);
    chk("frame_valid", fv, ch == 3);
    chk("store", chv(ch), exp_ch[ch]);
`ifdef ADC_SCAN_TIMEOUT_EN
    chk("err", err, exp_err);
`endif
    if (ch < 3) tick;
  endtask

  task automatic frame(input bit fixed, input bit drop,
                       input int lat1, input bit silent1);
    for (int c = 0; c < 4; c++) begin
      int lat;
      logic [W-1:0] d;
      lat = fixed ? 10 : int'($urandom_range(1, 12));
      d = fixed ? W'(12'h100 + c) : W'($urandom);
      if (c == 1 && lat1 > 0) lat = lat1;
      do_channel(c, lat, d, (c == 1) && silent1, (c == 1) && drop);
    end
    chk("frame_regs", {c3, c2, c1, c0},
        {exp_ch[3], exp_ch[2], exp_ch[1], exp_ch[0]});
  endtask

  // From the frame_valid cycle to the first START of the next frame
  task automatic gap_check;
    bit bad;
    bad = 1'b0;
    for (int i = 1; i <= GAP; i++) begin
      tick;
      if (spi_start !== 1'b0 || sel !== 2'd0 ||
          busy !== 1'b1 || fv !== 1'b0) bad = 1'b1;
      spi_done = 1'($urandom_range(0, 1));
      spi_data = W'($urandom);
    end
    tick;
    spi_done = 1'b0;
    chk("gap_quiet", bad, 0);
    chk("gap_start", spi_start, 1);
    chk("gap_regs", {c3, c2, c1, c0},
        {exp_ch[3], exp_ch[2], exp_ch[1], exp_ch[0]});
  endtask

  initial begin
    bit bad;
    for (int i = 0; i < 4; i++) exp_ch[i] = '0;
    #12;
    chk("rst_sel", sel, 0);
    chk("rst_start", spi_start, 0);
    chk("rst_fv", fv, 0);
    chk("rst_busy", busy, 0);
    chk("rst_regs", {c3, c2, c1, c0}, 0);
`ifdef ADC_SCAN_TIMEOUT_EN
    chk("rst_err", err, 0);
`endif
    tick;
    rst_n = 1'b1;
    tick;
    tick;
    chk("idle_busy", busy, 0);

    en = 1'b1;
    tick;
    frame(1'b1, 1'b0, 0, 1'b0);
    gap_check;
    repeat (5) begin
      frame(1'b0, 1'b0, 0, 1'b0);
      gap_check;
    end

    frame(1'b0, 1'b1, 0, 1'b0);
    tick;
    chk("drop_busy", busy, 0);
    chk("drop_sel", sel, 0);
    bad = 1'b0;
    repeat (20) begin
      spi_done = 1'($urandom_range(0, 1));
      spi_data = W'($urandom);
      tick;
      if (spi_start !== 1'b0 || busy !== 1'b1 - 1'b1 || fv !== 1'b0)
        bad = 1'b1;
    end
    spi_done = 1'b0;
    chk("idle_quiet", bad, 0);
    chk("idle_regs", {c3, c2, c1, c0},
        {exp_ch[3], exp_ch[2], exp_ch[1], exp_ch[0]});

    en = 1'b1;
    tick;
    do_channel(0, int'($urandom_range(1, 12)), W'($urandom), 1'b0, 1'b0);
    do_channel(1, int'($urandom_range(1, 12)), W'($urandom), 1'b0, 1'b0);
    chk("pre_rst_sel", sel, 2);
    tick;
    tick;
    tick;
    en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) exp_ch[i] = '0;
    exp_err = 1'b0;
    chk("arst_sel", sel, 0);
    chk("arst_start", spi_start, 0);
    chk("arst_busy", busy, 0);
    chk("arst_fv", fv, 0);
    chk("arst_regs", {c3, c2, c1, c0}, 0);
    tick;
    rst_n = 1'b1;
    tick;
    spi_done = 1'b1;
    spi_data = W'($urandom);
    tick;
    spi_done = 1'b0;
    tick;
    chk("late_done_regs", {c3, c2, c1, c0}, 0);
    chk("late_done_busy", busy, 0);
    chk("late_done_sel", sel, 0);

`ifdef ADC_SCAN_TIMEOUT_EN
    en = 1'b1;
    tick;
    frame(1'b0, 1'b0, TO, 1'b0);
    gap_check;
    frame(1'b0, 1'b0, TO, 1'b1);
    chk("err_sticky", err, 1);
    en = 1'b0;
    tick;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
